// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester byte-serialising RAM write arbiter.
package ram_arb_pkg;

    localparam int BYTE_W     = 8;
    localparam int ADDR_W_DEF = 16;
    localparam int WORD_W_DEF = 2 * BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the requester not granted last wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       RST,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant_oh,
    output logic       grant_idx
);

    logic r_last;

    always_comb begin
        grant_idx = 1'b0;
        grant_oh  = 2'b00;
        if (valid == 2'b11) begin
            grant_idx = ~r_last;
        end else if (valid[1]) begin
            grant_idx = 1'b1;
        end
        if (valid != 2'b00) begin
            grant_oh = grant_idx ? 2'b10 : 2'b01;
        end
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_last <= 1'b1;
        end else if (advance) begin
            r_last <= grant_idx;
        end
    end

endmodule

// File: rtl/ram_write_arbiter.sv
// Arbitrates two 16-bit word requesters onto a byte-wide RAM write port, high byte first.
// Optional per-requester word limit is enabled with the RAM_ARB_LIMIT_EN macro.
module ram_write_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              req0_start,
    input  logic              req1_start,
    input  logic [ADDR_W-1:0] req0_base,
    input  logic [ADDR_W-1:0] req1_base,
    input  logic              req0_valid,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req0_data,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req0_ready,
    output logic              req1_ready,
`ifdef RAM_ARB_LIMIT_EN
    input  logic [ADDR_W-1:0] req0_len,
    input  logic [ADDR_W-1:0] req1_len,
    output logic              req0_done,
    output logic              req1_done,
`endif
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BYTE_W-1:0] ram_data,
    output logic              busy,
    output logic              grant,
    output logic [1:0]        dbg_state
);

    // Handshake: a word moves when reqN_valid && reqN_ready at a rising edge; ready is
    // combinational, high only in IDLE/LO for the single requester picked by the arbiter.

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_window;
    logic              w_accept;
    logic [1:0]        w_lim;
    logic [1:0]        w_req_valid;
    logic [1:0]        w_gnt_oh;
    logic              w_gnt_idx;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_sel_start;
    logic [ADDR_W-1:0] w_sel_base;
    logic [ADDR_W-1:0] w_sel_ptr;
    logic [WORD_W-1:0] w_sel_data;

    logic [ADDR_W-1:0] r_ptr0;
    logic [ADDR_W-1:0] r_ptr1;
    logic [BYTE_W-1:0] r_word_lo;
    logic              r_grant;
    logic              r_ram_write;
    logic [ADDR_W-1:0] r_ram_address;
    logic [BYTE_W-1:0] r_ram_data;

    assign w_window    = (r_state == ST_IDLE) || (r_state == ST_LO);
    assign w_req_valid = {req1_valid & ~w_lim[1], req0_valid & ~w_lim[0]};
    assign w_accept    = RST & w_window & (|w_req_valid);
    assign w_acc0      = w_accept & ~w_gnt_idx;
    assign w_acc1      = w_accept &  w_gnt_idx;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .RST       (RST),
        .valid     (w_req_valid),
        .advance   (w_accept),
        .grant_oh  (w_gnt_oh),
        .grant_idx (w_gnt_idx)
    );

    assign req0_ready = w_accept & w_gnt_oh[0];
    assign req1_ready = w_accept & w_gnt_oh[1];

    // A start in the accept cycle redirects the accepted word to the new base.
    assign w_sel_start = w_gnt_idx ? req1_start : req0_start;
    assign w_sel_base  = w_gnt_idx ? req1_base  : req0_base;
    assign w_sel_ptr   = w_sel_start ? w_sel_base : (w_gnt_idx ? r_ptr1 : r_ptr0);
    assign w_sel_data  = w_gnt_idx ? req1_data  : req0_data;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_HI;
            ST_HI:   w_state_nxt = ST_LO;
            ST_LO:   w_state_nxt = w_accept ? ST_HI : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The pointer steps past the word as it is captured; the in-flight address lives in
    // r_ram_address, so a later start simply overrides the pointer for future words.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_ptr0 <= '0;
            r_ptr1 <= '0;
        end else begin
            if (w_acc0) begin
                r_ptr0 <= w_sel_ptr + ADDR_W'(2);
            end else if (req0_start) begin
                r_ptr0 <= req0_base;
            end
            if (w_acc1) begin
                r_ptr1 <= w_sel_ptr + ADDR_W'(2);
            end else if (req1_start) begin
                r_ptr1 <= req1_base;
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_word_lo     <= '0;
            r_grant       <= 1'b0;
            r_ram_write   <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
        end else if (w_accept) begin
            r_word_lo     <= w_sel_data[BYTE_W-1:0];
            r_grant       <= w_gnt_idx;
            r_ram_write   <= 1'b1;
            r_ram_address <= w_sel_ptr;
            r_ram_data    <= w_sel_data[WORD_W-1 -: BYTE_W];
        end else if (r_state == ST_HI) begin
            r_ram_write   <= 1'b1;
            r_ram_address <= r_ram_address + ADDR_W'(1);
            r_ram_data    <= r_word_lo;
        end else begin
            r_ram_write   <= 1'b0;
        end
    end

`ifdef RAM_ARB_LIMIT_EN
    logic [ADDR_W-1:0] r_cnt0;
    logic [ADDR_W-1:0] r_cnt1;
    logic              r_done0;
    logic              r_done1;
    logic [ADDR_W-1:0] w_cnt0_nxt;
    logic [ADDR_W-1:0] w_cnt1_nxt;

    always_comb begin
        w_cnt0_nxt = r_cnt0 + ADDR_W'(w_acc0);
        w_cnt1_nxt = r_cnt1 + ADDR_W'(w_acc1);
        if (req0_start) w_cnt0_nxt = ADDR_W'(w_acc0);
        if (req1_start) w_cnt1_nxt = ADDR_W'(w_acc1);
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_cnt0  <= '0;
            r_cnt1  <= '0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
        end else begin
            r_cnt0 <= w_cnt0_nxt;
            r_cnt1 <= w_cnt1_nxt;
            if (req0_start || w_acc0) r_done0 <= (w_cnt0_nxt == req0_len);
            if (req1_start || w_acc1) r_done1 <= (w_cnt1_nxt == req1_len);
        end
    end

    assign w_lim     = {r_done1, r_done0};
    assign req0_done = r_done0;
    assign req1_done = r_done1;
`else
    assign w_lim = 2'b00;
`endif

    assign ram_write   = r_ram_write;
    assign ram_address = r_ram_address;
    assign ram_data    = r_ram_data;
    assign busy        = (r_state != ST_IDLE);
    assign grant       = r_grant;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Self-checking bench for ram_write_arbiter: vector table, hand sequences, write scoreboard.
module tb_ram_write_arbiter;
    import ram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        req0_start = 1'b0, req1_start = 1'b0;
    logic [15:0] req0_base = '0, req1_base = '0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic        ram_write;
    logic [15:0] ram_address;
    logic [7:0]  ram_data;
    logic        busy, grant;
    logic [1:0]  dbg_state;
`ifdef RAM_ARB_LIMIT_EN
    logic [15:0] req0_len = 16'd100, req1_len = 16'd100;
    logic        req0_done, req1_done;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [23:0] exp_q[$];
    logic [15:0] m_ptr[2];

    ram_write_arbiter dut (
        .clk(clk), .RST(RST),
        .req0_start(req0_start), .req1_start(req1_start),
        .req0_base(req0_base), .req1_base(req1_base),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
`ifdef RAM_ARB_LIMIT_EN
        .req0_len(req0_len), .req1_len(req1_len),
        .req0_done(req0_done), .req1_done(req1_done),
`endif
        .ram_write(ram_write), .ram_address(ram_address), .ram_data(ram_data),
        .busy(busy), .grant(grant), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every RAM byte write must match the oldest expected {address, data}.
    always @(negedge clk) begin
        if (RST && ram_write) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_write actual=%h expected=none", {ram_address, ram_data});
            end else begin
                check("sb_write", {8'h00, ram_address, ram_data}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_start = 1'b0; req1_start = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 RST = 1'b1;
        m_ptr[0] = '0;
        m_ptr[1] = '0;
        exp_q.delete();
    endtask

    task automatic do_start(input int r, input logic [15:0] base);
        if (r == 0) begin req0_start = 1'b1; req0_base = base; end
        else        begin req1_start = 1'b1; req1_base = base; end
        @(posedge clk);
        #1 clear_inputs();
        m_ptr[r] = base;
    endtask

    // st: 0 = no start, 1 = start the cycle before, 2 = start in the accept cycle.
    task automatic send_word(input int r, input logic [15:0] data, input int st,
                             input logic [15:0] base, output bit ok);
        if (st == 1) do_start(r, base);
        if (r == 0) begin
            req0_valid = 1'b1; req0_data = data;
            if (st == 2) begin req0_start = 1'b1; req0_base = base; end
        end else begin
            req1_valid = 1'b1; req1_data = data;
            if (st == 2) begin req1_start = 1'b1; req1_base = base; end
        end
        if (st == 2) m_ptr[r] = base;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((r == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            exp_q.push_back({m_ptr[r], data[15:8]});
            exp_q.push_back({m_ptr[r] + 16'd1, data[7:0]});
            m_ptr[r] = m_ptr[r] + 16'd2;
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout actual=no_ready expected=ready req=%0d", r);
        end
        @(posedge clk);
        #1 clear_inputs();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          req;
        int          st;
        logic [15:0] base;
        logic [15:0] data;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t        tbl[8];
    bit          ok;
    logic [15:0] a1;
    logic [15:0] rb;
    int          n_acc, first_c, g;

    initial begin
        tbl[0] = '{0, 1, 16'h0100, 16'hABCD, 16'h0100};
        tbl[1] = '{1, 2, 16'h4000, 16'h5A5A, 16'h4000};
        tbl[2] = '{0, 1, 16'hFFFF, 16'h1234, 16'hFFFF};
        tbl[3] = '{0, 0, 16'h0000, 16'h9876, 16'h0001};
        tbl[4] = '{1, 0, 16'h0000, 16'h00FF, 16'h4002};
        tbl[5] = '{1, 2, 16'h7FFE, 16'hC3C3, 16'h7FFE};
        for (int i = 6; i < 8; i++) begin
            rb = 16'($urandom_range(0, 16'hFFFF));
            tbl[i] = '{int'($urandom_range(0, 1)), 1, rb, 16'($urandom_range(0, 16'hFFFF)), rb};
        end

        // Reset values, with requests already pending.
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ram_write", {31'd0, ram_write}, 32'd0);
        check("rst_ram_address", {16'd0, ram_address}, 32'd0);
        check("rst_ram_data", {24'd0, ram_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {31'd0, grant}, 32'd0);
        check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            send_word(tbl[i].req, tbl[i].data, tbl[i].st, tbl[i].base, ok);
            a1 = tbl[i].exp_addr + 16'd1;
            @(negedge clk);
            check("hi_write", {31'd0, ram_write}, 32'd1);
            check("hi_addr", {16'd0, ram_address}, {16'd0, tbl[i].exp_addr});
            check("hi_data", {24'd0, ram_data}, {24'd0, tbl[i].data[15:8]});
            check("hi_grant", {31'd0, grant}, tbl[i].req);
            check("hi_state", {30'd0, dbg_state}, {30'd0, ST_HI});
            @(negedge clk);
            check("lo_addr", {16'd0, ram_address}, {16'd0, a1});
            check("lo_data", {24'd0, ram_data}, {24'd0, tbl[i].data[7:0]});
            @(negedge clk);
            check("idle_write", {31'd0, ram_write}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_addr_hold", {16'd0, ram_address}, {16'd0, a1});
            @(posedge clk);
            #1;
        end

        // Start asserted during HI of an in-flight word.
        do_start(0, 16'h0010);
        req0_valid = 1'b1; req0_data = 16'h2468;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = req0_ready;
        end
        check("mid_start_accept", {31'd0, ok}, 32'd1);
        exp_q.push_back({16'h0010, 8'h24});
        exp_q.push_back({16'h0011, 8'h68});
        @(posedge clk);
        #1 req0_valid = 1'b0; req0_start = 1'b1; req0_base = 16'h0200;
        @(negedge clk);
        check("mid_start_in_hi", {30'd0, dbg_state}, {30'd0, ST_HI});
        @(posedge clk);
        #1 req0_start = 1'b0;
        m_ptr[0] = 16'h0200;
        wait_idle();
        send_word(0, 16'h1357, 0, 16'h0000, ok);
        @(negedge clk);
        check("mid_start_next_addr", {16'd0, ram_address}, 32'h0200);
        wait_idle();

        // Contention from reset: grants alternate 0,1,0,1 with no idle gap.
        do_reset();
        req0_start = 1'b1; req0_base = 16'h0000;
        req1_start = 1'b1; req1_base = 16'h8000;
        @(posedge clk);
        #1 clear_inputs();
        m_ptr[0] = 16'h0000; m_ptr[1] = 16'h8000;
        req0_valid = 1'b1; req0_data = 16'h1111;
        req1_valid = 1'b1; req1_data = 16'h2222;
        n_acc = 0; first_c = 0;
        for (int c = 0; c < 30 && n_acc < 4; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                check("rr_single_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
                g = req1_ready ? 1 : 0;
                check("rr_order", g, n_acc % 2);
                if (n_acc == 0) first_c = c;
                else check("rr_spacing", c - first_c, 2 * n_acc);
                exp_q.push_back({m_ptr[g], (g == 0) ? 8'h11 : 8'h22});
                exp_q.push_back({m_ptr[g] + 16'd1, (g == 0) ? 8'h11 : 8'h22});
                m_ptr[g] = m_ptr[g] + 16'd2;
                n_acc++;
            end
        end
        check("rr_accepts", n_acc, 4);
        @(posedge clk);
        #1 clear_inputs();
        wait_idle();

        // Reset during HI aborts the word.
        do_start(0, 16'h0300);
        req0_valid = 1'b1; req0_data = 16'hBEEF;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = req0_ready;
        end
        check("rst_mid_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        check("rst_mid_hi_write", {31'd0, ram_write}, 32'd1);
        #1 RST = 1'b0;
        req0_valid = 1'b1;
        #1;
        check("rst_mid_write_drop", {31'd0, ram_write}, 32'd0);
        check("rst_mid_ready_low", {30'd0, req1_ready, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 RST = 1'b1;
        m_ptr[0] = '0; m_ptr[1] = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid_no_lo", {31'd0, ram_write}, 32'd0);
        end
        @(posedge clk);
        #1;
        send_word(0, 16'hA5C3, 0, 16'h0000, ok);
        @(negedge clk);
        check("rst_ptr0_zero", {16'd0, ram_address}, 32'h0000);
        wait_idle();
        send_word(1, 16'h3C5A, 0, 16'h0000, ok);
        @(negedge clk);
        check("rst_ptr1_zero", {16'd0, ram_address}, 32'h0000);
        wait_idle();

`ifdef RAM_ARB_LIMIT_EN
        req0_len = 16'd3;
        do_start(0, 16'h0A00);
        for (int k = 0; k < 3; k++) begin
            send_word(0, 16'h0F00 + 16'(k), 0, 16'h0000, ok);
            wait_idle();
        end
        check("lim_done", {31'd0, req0_done}, 32'd1);
        req0_valid = 1'b1; req0_data = 16'hDEAD;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("lim_ready_low", {31'd0, req0_ready}, 32'd0);
        end
        @(posedge clk);
        #1 clear_inputs();
        do_start(0, 16'h0B00);
        check("lim_done_cleared", {31'd0, req0_done}, 32'd0);
        send_word(0, 16'h7777, 0, 16'h0000, ok);
        check("lim_restart_accept", {31'd0, ok}, 32'd1);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
